trace_slot_controller: RTL
==========================

Name: trace_slot_controller

Overview:
- Controller for the pipeline trace-record buffer used by the CPU debug and verification infrastructure.
- Allocates a ring-buffer slot to each fetched instruction and tracks that slot's ID through IF/ID/EX/MEM/WB under stall and flush.
- Marks slots retired at WB.
- Releases retired slots in program order through a print request/acknowledge handshake, so the printer consumes complete records oldest-first.

Parameters:
- DEPTH, 8: number of trace slots; power of 2, at least 8.
- ID_W, $clog2(DEPTH): slot-index width.
- SEQ_W, 16: instruction sequence-number width; wraps modulo 2^SEQ_W.
- STALL_W, 3: width of the per-instruction stall index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- fetch_valid  in  1  an instruction is fetched into IF this cycle.
- stall  in  1  hazard stall: IF and ID hold, bubble into EX.
- flush  in  1  squash the instruction in IF (taken branch).
- print_ack  in  1  printer has consumed the record at print_slot.
- if_v, id_v, ex_v, mem_v, wb_v  out  1 each  stage holds a tracked instruction.
- if_slot, id_slot, ex_slot, mem_slot, wb_slot  out  ID_W each  slot index per stage.
- stall_idx  out  STALL_W  consecutive stall cycles seen by the IF instruction.
- print_req  out  1  the oldest slot is retired and ready to print.
- print_slot  out  ID_W  slot index to print.
- print_seq  out  SEQ_W  sequence number of print_slot.
- full  out  1  all DEPTH slots are occupied.
- overflow  out  1  sticky: fetch_valid arrived while full.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All stage valids, pointers, count, seq counter, stall_idx, print_req and overflow go to 0.
  - All slot states go to FREE.
  - Slot index outputs go to 0.
  - Reset mid-operation discards every record, including unprinted ones.
- Slot state per entry is FREE, INFLIGHT or RETIRED.
  - FREE -> INFLIGHT on allocation.
  - INFLIGHT -> RETIRED when the slot is in WB with wb_v=1.
  - INFLIGHT -> FREE on flush.
  - RETIRED -> FREE on print_ack while the slot is at the head.
- Ring bookkeeping:
  - Registers are head (oldest), tail (next allocation) and count (0..DEPTH).
  - full = (count == DEPTH), taken from the registered count. An ack in the same cycle does not enable allocation.
- Allocation:
  - Condition: fetch_valid && !stall && !full.
  - The IF stage takes slot tail. The slot stores seq; seq increments, tail increments, count increments.
  - If fetch_valid && full: no allocation, IF loads a bubble, overflow sets and stays set until reset.
- Normal advance (!stall, !flush): wb<=mem, mem<=ex, ex<=id, id<=if, IF loads the new allocation or a bubble. All updates are registered, with 1-cycle latency per stage.
- Stall (stall=1, flush=0):
  - IF and ID hold their valid and slot.
  - EX loads a bubble; MEM and WB advance.
  - stall_idx increments if if_v=1, saturating at 2^STALL_W-1.
- Flush (flush has priority over stall):
  - If if_v=1, the IF slot returns to FREE, tail decrements and count decrements. The IF slot is always the youngest, so the ring stays contiguous.
  - ID loads a bubble; EX<=ID, MEM and WB advance.
  - An allocation in the same cycle is permitted and reuses the freed index. The net effect is tail unchanged and count unchanged.
- stall_idx clears to 0 whenever IF loads (new instruction or bubble).
- Print handshake:
  - print_req = 1 exactly when count>0 and slot[head] is RETIRED. print_slot=head and print_seq=seq[head].
  - print_req, print_slot and print_seq hold stable until print_ack.
  - When print_ack && print_req: slot[head] goes FREE, head increments, count decrements. The next request can be presented in the following cycle.
  - print_ack without print_req is ignored.
- Simultaneous allocation and ack: count is unchanged, and both pointers move.
- Pointers wrap modulo DEPTH; seq wraps modulo 2^SEQ_W.
- A retired slot blocks reuse until printed. A slow printer therefore drives full, and the CPU-side bench must tolerate a dropped fetch, which is flagged by overflow.

Decomposition:
- Shared package trace_pkg:
  - slot_state_t enum (FREE, INFLIGHT, RETIRED).
  - stage_tag_t struct {logic v; logic [ID_W-1:0] slot;}.
  - TRACE_DEPTH constant.
- Sub-module trace_stage_pipe: the IF..WB valid/slot shift register with stall/flush rules.
- The top level holds the ring, slot states, seq storage and print handshake.

Test Plan:
- Reset, then fetch_valid=1 for 5 cycles with print_ack tied 1:
  - Slots 0..4 appear in WB on cycles 5..9.
  - print_req is seen with print_seq 0,1,2,3,4 in order.
  - count returns to 0.
- Instruction in IF at slot 2, stall for 3 cycles:
  - if_slot and id_slot hold, stall_idx reads 1,2,3.
  - ex_v=0 for 3 cycles.
  - stall_idx returns to 0 after release.
- flush with IF=slot 3 and fetch_valid=1:
  - Slot 3 is reallocated to the new instruction with seq+1.
  - Squashed seq is never printed; id_v=0 the next cycle.
- print_ack held 0 with DEPTH=8 and continuous fetch:
  - full=1 after 8 allocations.
  - The 9th fetch sets overflow=1 and IF gets a bubble.
  - print_req holds with print_slot=0 until the ack.
- rst_n=0 with 4 retired, unprinted slots:
  - Next cycle print_req=0, count=0, overflow=0.
  - The first new allocation gets slot 0, seq 0.
- Simultaneous ack and allocation at count=8:
  - The allocation is refused that cycle because full is registered.
  - The next cycle it succeeds, with count=8 and head and tail both advanced.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace-record slot controller.
//   slot_state_t : lifecycle of one trace slot (FREE -> INFLIGHT -> RETIRED -> FREE)
//   stage_tag_t  : valid + slot index carried by a pipeline stage (default depth)
//   STG_*        : stage positions inside the IF..WB shift register
package trace_pkg;

  localparam int TRACE_DEPTH   = 8;
  localparam int TRACE_ID_W    = $clog2(TRACE_DEPTH);
  localparam int TRACE_SEQ_W   = 16;
  localparam int TRACE_STALL_W = 3;

  localparam int NUM_STAGES = 5;
  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    INFLIGHT = 2'd1,
    RETIRED  = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic                  v;
    logic [TRACE_ID_W-1:0] slot;
  } stage_tag_t;

endpackage

// File: rtl/trace_stage_pipe.sv
// IF..WB valid/slot shift register for the trace slot controller.
//   clk, rst_n    : clock, synchronous active-low reset
//   stall         : IF/ID hold, bubble into EX, MEM/WB advance
//   flush         : IF squashed and reloaded from new_*, bubble into ID, EX<=ID
//   new_v/new_slot: what IF loads when it loads (allocation or bubble)
//   stage_v/slot  : per-stage valid and slot index, indexed by STG_*
//   stall_idx     : consecutive stall cycles seen by the instruction in IF
// Bubbles carry slot index 0 so idle stages read as all-zero.
module trace_stage_pipe
  import trace_pkg::*;
#(
  parameter int ID_W    = TRACE_ID_W,
  parameter int STALL_W = TRACE_STALL_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic                             flush,
  input  logic                             new_v,
  input  logic [ID_W-1:0]                  new_slot,
  output logic [NUM_STAGES-1:0]            stage_v,
  output logic [NUM_STAGES-1:0][ID_W-1:0]  stage_slot,
  output logic [STALL_W-1:0]               stall_idx
);

  logic [NUM_STAGES-1:0]           v_q, v_d;
  logic [NUM_STAGES-1:0][ID_W-1:0] slot_q, slot_d;
  logic [STALL_W-1:0]              stall_idx_q, stall_idx_d;
  logic [ID_W-1:0]                 new_slot_m;

  assign new_slot_m = new_v ? new_slot : '0;

  always_comb begin
    v_d         = v_q;
    slot_d      = slot_q;
    stall_idx_d = stall_idx_q;

    // MEM and WB advance under every condition.
    v_d[STG_WB]     = v_q[STG_MEM];
    slot_d[STG_WB]  = slot_q[STG_MEM];
    v_d[STG_MEM]    = v_q[STG_EX];
    slot_d[STG_MEM] = slot_q[STG_EX];

    if (flush) begin
      // Flush wins over stall: IF is squashed, the older ID instruction survives.
      v_d[STG_IF]    = new_v;
      slot_d[STG_IF] = new_slot_m;
      v_d[STG_ID]    = 1'b0;
      slot_d[STG_ID] = '0;
      v_d[STG_EX]    = v_q[STG_ID];
      slot_d[STG_EX] = slot_q[STG_ID];
      stall_idx_d    = '0;
    end else if (stall) begin
      v_d[STG_EX]    = 1'b0;
      slot_d[STG_EX] = '0;
      if (v_q[STG_IF] && (stall_idx_q != {STALL_W{1'b1}})) begin
        stall_idx_d = stall_idx_q + STALL_W'(1);
      end
    end else begin
      v_d[STG_IF]    = new_v;
      slot_d[STG_IF] = new_slot_m;
      v_d[STG_ID]    = v_q[STG_IF];
      slot_d[STG_ID] = slot_q[STG_IF];
      v_d[STG_EX]    = v_q[STG_ID];
      slot_d[STG_EX] = slot_q[STG_ID];
      stall_idx_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q         <= '0;
      slot_q      <= '0;
      stall_idx_q <= '0;
    end else begin
      v_q         <= v_d;
      slot_q      <= slot_d;
      stall_idx_q <= stall_idx_d;
    end
  end

  assign stage_v    = v_q;
  assign stage_slot = slot_q;
  assign stall_idx  = stall_idx_q;

endmodule

// File: rtl/trace_slot_controller.sv
// Trace-record slot controller: allocates a ring slot per fetched instruction,
// tracks it through IF..WB, marks it retired at WB and hands retired slots to
// the printer oldest-first.
//   clk, rst_n            : clock, synchronous active-low reset
//   fetch_valid/stall/flush: CPU pipeline control
//   print_req/slot/seq    : request to print the head record
//   print_ack             : printer consumed the head record
//   *_v, *_slot           : per-stage valid and slot index
//   stall_idx             : consecutive stalls of the IF instruction (saturating)
//   full, overflow        : ring full (registered count), sticky dropped fetch
//
// Print handshake: print_req is a valid that depends only on registered state,
// so print_req/print_slot/print_seq stay stable until print_ack. A transfer
// happens on a cycle with print_req && print_ack; print_ack alone is ignored.
module trace_slot_controller
  import trace_pkg::*;
#(
  parameter int DEPTH   = TRACE_DEPTH,
  parameter int ID_W    = $clog2(DEPTH),
  parameter int SEQ_W   = TRACE_SEQ_W,
  parameter int STALL_W = TRACE_STALL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               print_ack,
  output logic               if_v,
  output logic               id_v,
  output logic               ex_v,
  output logic               mem_v,
  output logic               wb_v,
  output logic [ID_W-1:0]    if_slot,
  output logic [ID_W-1:0]    id_slot,
  output logic [ID_W-1:0]    ex_slot,
  output logic [ID_W-1:0]    mem_slot,
  output logic [ID_W-1:0]    wb_slot,
  output logic [STALL_W-1:0] stall_idx,
  output logic               print_req,
  output logic [ID_W-1:0]    print_slot,
  output logic [SEQ_W-1:0]   print_seq,
  output logic               full,
  output logic               overflow
);

  logic [ID_W-1:0]  head_q, head_d;
  logic [ID_W-1:0]  tail_q, tail_d;
  logic [ID_W:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  slot_state_t      state_q [DEPTH];
  slot_state_t      state_d [DEPTH];
  logic [SEQ_W-1:0] seq_mem_q [DEPTH];
  logic [SEQ_W-1:0] seq_mem_d [DEPTH];

  logic             alloc;
  logic             flush_free;
  logic             ack;
  logic [ID_W-1:0]  alloc_idx;

  logic [NUM_STAGES-1:0]           stage_v;
  logic [NUM_STAGES-1:0][ID_W-1:0] stage_slot;

  assign full       = (count_q == (ID_W+1)'(DEPTH));
  assign print_req  = (count_q != '0) && (state_q[head_q] == RETIRED);
  assign print_slot = head_q;
  assign print_seq  = seq_mem_q[head_q];
  assign overflow   = overflow_q;

  assign alloc      = fetch_valid && !stall && !full;
  assign flush_free = flush && if_v;
  assign ack        = print_ack && print_req;
  // The IF instruction is always the youngest, so its slot is tail-1; a flush
  // plus fetch in the same cycle reuses it and the ring stays contiguous.
  assign alloc_idx  = flush_free ? (tail_q - ID_W'(1)) : tail_q;

  always_comb begin
    state_d    = state_q;
    seq_mem_d  = seq_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    seq_d      = seq_q;
    overflow_d = overflow_q | (fetch_valid & full);

    if (wb_v)       state_d[wb_slot] = RETIRED;
    if (flush_free) state_d[if_slot] = FREE;
    if (ack) begin
      state_d[head_q] = FREE;
      head_d          = head_q + ID_W'(1);
    end
    if (alloc) begin
      state_d[alloc_idx]   = INFLIGHT;
      seq_mem_d[alloc_idx] = seq_q;
      seq_d                = seq_q + SEQ_W'(1);
    end

    if (alloc && !flush_free) begin
      tail_d = tail_q + ID_W'(1);
    end else if (!alloc && flush_free) begin
      tail_d = tail_q - ID_W'(1);
    end

    count_d = count_q + (ID_W+1)'(alloc) - (ID_W+1)'(flush_free) - (ID_W+1)'(ack);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]   <= FREE;
        seq_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]   <= state_d[i];
        seq_mem_q[i] <= seq_mem_d[i];
      end
    end
  end

  trace_stage_pipe #(
    .ID_W    (ID_W),
    .STALL_W (STALL_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .new_v      (alloc),
    .new_slot   (alloc ? alloc_idx : '0),
    .stage_v    (stage_v),
    .stage_slot (stage_slot),
    .stall_idx  (stall_idx)
  );

  assign if_v     = stage_v[STG_IF];
  assign id_v     = stage_v[STG_ID];
  assign ex_v     = stage_v[STG_EX];
  assign mem_v    = stage_v[STG_MEM];
  assign wb_v     = stage_v[STG_WB];
  assign if_slot  = stage_slot[STG_IF];
  assign id_slot  = stage_slot[STG_ID];
  assign ex_slot  = stage_slot[STG_EX];
  assign mem_slot = stage_slot[STG_MEM];
  assign wb_slot  = stage_slot[STG_WB];

endmodule
